// File: rtl/pattern_edge_checker_if.sv
// Pattern link bundle: serial pattern input plus the checker's status outputs.
// The slave side is the checker; the master side drives the pattern and reads status.
interface pattern_edge_checker_if #(
    parameter int CNT_W = 16
);
    logic             pat_in;
    logic             in_sync;
    logic             frame_ok;
    logic             seg_err;
    logic [2:0]       err_idx;
    logic [CNT_W-1:0] err_len;
    logic [CNT_W-1:0] frame_cnt;
    logic [7:0]       err_cnt;

    modport slave (
        input  pat_in,
        output in_sync, frame_ok, seg_err, err_idx, err_len, frame_cnt, err_cnt
    );

    modport master (
        output pat_in,
        input  in_sync, frame_ok, seg_err, err_idx, err_len, frame_cnt, err_cnt
    );
endinterface

// File: rtl/pattern_edge_checker.sv
// Receive-side checker for a periodic single-bit timing pattern.
// Synchronises pat_in, measures every high/low segment length in clock cycles and
// compares it against a per-segment schedule (even index = high, odd index = low).
// Reports frame-good / segment-error pulses plus held error details and counters.
module pattern_edge_checker #(
    parameter int                    CNT_W   = 16,
    parameter int                    NSEG    = 6,
    parameter logic [NSEG*CNT_W-1:0] SEG_LEN = {16'd100, 16'd60, 16'd50, 16'd40, 16'd30, 16'd20},
    parameter int                    TOL     = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pattern_edge_checker_if.slave  bus
);

    localparam int                      IDX_W    = $clog2(NSEG);
    localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(NSEG - 1);
    localparam logic signed [CNT_W:0]   TOL_S    = (CNT_W + 1)'(TOL);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    // Error counter increment that saturates at 255.
    function automatic logic [7:0] sat_inc_err(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Expected length of segment idx from the packed schedule.
    function automatic logic [CNT_W-1:0] seg_len_at(input logic [IDX_W-1:0] idx);
        logic [CNT_W-1:0] r;
        r = '0;
        for (int i = 0; i < NSEG; i++) begin
            if (idx == IDX_W'(i)) begin
                r = SEG_LEN[i*CNT_W +: CNT_W];
            end
        end
        return r;
    endfunction

    // |measured - expected| <= TOL, done one bit wider and signed so the difference never wraps.
    function automatic logic within_tol(input logic [CNT_W-1:0] meas, input logic [CNT_W-1:0] expd);
        logic signed [CNT_W:0] diff;
        diff = $signed({1'b0, meas}) - $signed({1'b0, expd});
        return (diff <= TOL_S) && (diff >= -TOL_S);
    endfunction

    // Synchroniser and last-value flop
    logic s1_q, s2_q, s3_q;

    // Measurement and FSM state
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] seg_idx_q, seg_idx_d;

    // Registered outputs
    logic             in_sync_q, in_sync_d;
    logic             frame_ok_q, frame_ok_d;
    logic             seg_err_q, seg_err_d;
    logic [2:0]       err_idx_q, err_idx_d;
    logic [CNT_W-1:0] err_len_q, err_len_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [7:0]       err_cnt_q, err_cnt_d;

    // Edge detect and segment decision terms
    logic             edge_w;
    logic             rise_w;
    logic [CNT_W-1:0] exp_len_w;
    logic [CNT_W-1:0] limit_w;
    logic             pol_ok_w;
    logic             seg_ok_w;
    logic             timeout_w;

    assign edge_w    = s2_q ^ s3_q;
    assign rise_w    = s2_q & ~s3_q;
    assign exp_len_w = seg_len_at(seg_idx_q);
    assign limit_w   = exp_len_w + CNT_W'(TOL);
    // s3 still holds the level of the segment that just ended: high for even indices.
    assign pol_ok_w  = (s3_q == ~seg_idx_q[0]);
    assign seg_ok_w  = within_tol(cnt_q, exp_len_w) && pol_ok_w;
    // One cycle past the upper bound with no edge: the segment can no longer be in range.
    assign timeout_w = ~edge_w && (cnt_q == limit_w);

    // Next-state and output decode for the lock/track state machine.
    always_comb begin
        logic             take_err;
        logic [CNT_W-1:0] bad_len;

        take_err    = 1'b0;
        bad_len     = cnt_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        seg_idx_d   = seg_idx_q;
        frame_ok_d  = 1'b0;
        seg_err_d   = 1'b0;
        err_idx_d   = err_idx_q;
        err_len_d   = err_len_q;
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rise_w) begin
                    seg_idx_d = '0;
                    cnt_d     = CNT_W'(1);
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (edge_w) begin
                    if (seg_ok_w) begin
                        cnt_d = CNT_W'(1);
                        if (seg_idx_q == LAST_IDX) begin
                            // Closing rise of the frame also opens segment 0 of the next one.
                            seg_idx_d   = '0;
                            frame_ok_d  = 1'b1;
                            frame_cnt_d = frame_cnt_q + CNT_W'(1);
                        end else begin
                            seg_idx_d = seg_idx_q + IDX_W'(1);
                        end
                    end else begin
                        take_err = 1'b1;
                        bad_len  = cnt_q;
                    end
                end else if (timeout_w) begin
                    take_err = 1'b1;
                    bad_len  = sat_inc_cnt(cnt_q);
                end else begin
                    cnt_d = sat_inc_cnt(cnt_q);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // An error always drops lock; relock needs a fresh rise seen from IDLE.
        if (take_err) begin
            seg_err_d = 1'b1;
            err_idx_d = 3'(seg_idx_q);
            err_len_d = bad_len;
            err_cnt_d = sat_inc_err(err_cnt_q);
            seg_idx_d = '0;
            cnt_d     = '0;
            state_d   = IDLE;
        end

        in_sync_d = (state_d == RUN);
    end

    // All state, including the synchroniser, clears on reset so mid-frame progress is discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            s3_q        <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            seg_idx_q   <= '0;
            in_sync_q   <= 1'b0;
            frame_ok_q  <= 1'b0;
            seg_err_q   <= 1'b0;
            err_idx_q   <= '0;
            err_len_q   <= '0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            s1_q        <= bus.pat_in;
            s2_q        <= s1_q;
            s3_q        <= s2_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            seg_idx_q   <= seg_idx_d;
            in_sync_q   <= in_sync_d;
            frame_ok_q  <= frame_ok_d;
            seg_err_q   <= seg_err_d;
            err_idx_q   <= err_idx_d;
            err_len_q   <= err_len_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign bus.in_sync   = in_sync_q;
    assign bus.frame_ok  = frame_ok_q;
    assign bus.seg_err   = seg_err_q;
    assign bus.err_idx   = err_idx_q;
    assign bus.err_len   = err_len_q;
    assign bus.frame_cnt = frame_cnt_q;
    assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_pattern_edge_checker.sv
// Directed bench for pattern_edge_checker: a default-schedule instance for lock, tolerance,
// error, timeout, reset and saturation cases, and a tiny 4-bit instance for frame_cnt wrap.
module tb_pattern_edge_checker;

    logic clk = 1'b0;
    logic rst_n;
    logic rst2_n;

    always #5 clk = ~clk;

    pattern_edge_checker_if #(.CNT_W(16)) bus ();
    pattern_edge_checker_if #(.CNT_W(4))  bus2 ();

    pattern_edge_checker #(
        .CNT_W  (16),
        .NSEG   (6),
        .SEG_LEN({16'd100, 16'd60, 16'd50, 16'd40, 16'd30, 16'd20}),
        .TOL    (2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // seg0 high 3, seg1 low 3, TOL 1: 6-cycle frames, frame_cnt wraps after 16.
    pattern_edge_checker #(
        .CNT_W  (4),
        .NSEG   (2),
        .SEG_LEN({4'd3, 4'd3}),
        .TOL    (1)
    ) dut2 (
        .clk  (clk),
        .rst_n(rst2_n),
        .bus  (bus2)
    );

    int n_cmp = 0;
    int n_mis = 0;

    // Pulse tallies, sampled 1 ns after each rising edge.
    int n_fok  = 0;
    int n_err  = 0;
    int n_fok2 = 0;
    int n_err2 = 0;

    always begin
        @(posedge clk);
        #1;
        if (bus.frame_ok === 1'b1)  n_fok++;
        if (bus.seg_err === 1'b1)   n_err++;
        if (bus2.frame_ok === 1'b1) n_fok2++;
        if (bus2.seg_err === 1'b1)  n_err2++;
    end

    int seg_len_tb [6] = '{20, 30, 40, 50, 60, 100};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expd);
        n_cmp++;
        if (got !== expd) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, expd);
        end
    endtask

    // Drive a level on the main pattern for n rising edges (changes on falling edges).
    task automatic hold(input logic lvl, input int n);
        bus.pat_in = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic hold2(input logic lvl, input int n);
        bus2.pat_in = lvl;
        repeat (n) @(negedge clk);
    endtask

    // One full frame with every segment shifted by delta cycles.
    task automatic frame(input int delta);
        for (int i = 0; i < 6; i++) begin
            hold((i % 2) == 0, seg_len_tb[i] + delta);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.pat_in = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        hold(1'b0, 5);
    endtask

    int f0;
    int e0;

    initial begin
        rst_n       = 1'b0;
        rst2_n      = 1'b0;
        bus.pat_in  = 1'b0;
        bus2.pat_in = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_in_sync",   32'(bus.in_sync),   0);
        chk("rst_frame_cnt", 32'(bus.frame_cnt), 0);
        chk("rst_err_cnt",   32'(bus.err_cnt),   0);
        chk("rst_err_len",   32'(bus.err_len),   0);
        chk("rst_err_idx",   32'(bus.err_idx),   0);

        rst_n  = 1'b1;
        rst2_n = 1'b1;
        hold(1'b0, 5);
        chk("idle_in_sync", 32'(bus.in_sync), 0);

        // Clean 300-cycle frame
        f0 = n_fok;
        e0 = n_err;
        hold(1'b1, 5);
        chk("t1_lock", 32'(bus.in_sync), 1);
        hold(1'b1, 15);
        for (int i = 1; i < 6; i++) hold((i % 2) == 0, seg_len_tb[i]);
        hold(1'b1, 5);
        chk("t1_fok_pulses", n_fok - f0, 1);
        chk("t1_frame_cnt",  32'(bus.frame_cnt), 1);
        chk("t1_no_err",     n_err - e0, 0);
        chk("t1_in_sync",    32'(bus.in_sync), 1);

        // Tolerance edges: +2 / -2 on every segment
        do_reset();
        f0 = n_fok;
        e0 = n_err;
        for (int k = 0; k < 5; k++) frame(((k % 2) == 0) ? 2 : -2);
        hold(1'b1, 5);
        chk("t2_frame_cnt",  32'(bus.frame_cnt), 5);
        chk("t2_fok_pulses", n_fok - f0, 5);
        chk("t2_err_cnt",    32'(bus.err_cnt), 0);
        chk("t2_no_err",     n_err - e0, 0);

        // Segment 2 too long (43): timeout at cnt 42 -> err_len 43
        do_reset();
        f0 = n_fok;
        e0 = n_err;
        hold(1'b1, 20);
        hold(1'b0, 30);
        hold(1'b1, 43);
        hold(1'b0, 10);
        chk("t3_err_pulses", n_err - e0, 1);
        chk("t3_err_idx",    32'(bus.err_idx), 2);
        chk("t3_err_len",    32'(bus.err_len), 43);
        chk("t3_err_cnt",    32'(bus.err_cnt), 1);
        chk("t3_in_sync",    32'(bus.in_sync), 0);
        chk("t3_no_fok",     n_fok - f0, 0);
        hold(1'b0, 40);
        frame(0);
        hold(1'b1, 5);
        chk("t3_relock",     32'(bus.in_sync), 1);
        chk("t3_fok_pulses", n_fok - f0, 1);
        chk("t3_frame_cnt",  32'(bus.frame_cnt), 1);

        // Stuck low in segment 5: timeout at cnt 102 -> err_len 103
        do_reset();
        e0 = n_err;
        for (int i = 0; i < 5; i++) hold((i % 2) == 0, seg_len_tb[i]);
        hold(1'b0, 110);
        chk("t4_err_pulses", n_err - e0, 1);
        chk("t4_err_idx",    32'(bus.err_idx), 5);
        chk("t4_err_len",    32'(bus.err_len), 103);
        chk("t4_in_sync",    32'(bus.in_sync), 0);
        chk("t4_frame_cnt",  32'(bus.frame_cnt), 0);
        chk("t4_err_cnt",    32'(bus.err_cnt), 1);
        hold(1'b1, 5);
        chk("t4_relock",     32'(bus.in_sync), 1);

        // Reset at cycle 150 of the second frame
        do_reset();
        frame(0);
        hold(1'b1, 20);
        hold(1'b0, 30);
        hold(1'b1, 40);
        hold(1'b0, 50);
        hold(1'b1, 10);
        rst_n = 1'b0;
        hold(1'b1, 2);
        chk("t5_rst_in_sync",   32'(bus.in_sync),   0);
        chk("t5_rst_frame_ok",  32'(bus.frame_ok),  0);
        chk("t5_rst_seg_err",   32'(bus.seg_err),   0);
        chk("t5_rst_frame_cnt", 32'(bus.frame_cnt), 0);
        chk("t5_rst_err_cnt",   32'(bus.err_cnt),   0);
        chk("t5_rst_err_len",   32'(bus.err_len),   0);
        chk("t5_rst_err_idx",   32'(bus.err_idx),   0);
        hold(1'b1, 8);
        rst_n = 1'b1;
        f0 = n_fok;
        hold(1'b1, 50);
        hold(1'b0, 100);
        chk("t5_no_fok_partial", n_fok - f0, 0);
        frame(0);
        hold(1'b1, 5);
        chk("t5_fok_pulses", n_fok - f0, 1);
        chk("t5_frame_cnt",  32'(bus.frame_cnt), 1);

        // 260 bad frames (segment 0 held 25): err_cnt saturates, frame_cnt untouched
        do_reset();
        frame(0);
        e0 = n_err;
        for (int k = 0; k < 260; k++) begin
            hold(1'b1, 25);
            hold(1'b0, 5);
        end
        chk("t6_err_pulses", n_err - e0, 260);
        chk("t6_err_cnt",    32'(bus.err_cnt), 255);
        chk("t6_frame_cnt",  32'(bus.frame_cnt), 1);
        chk("t6_err_idx",    32'(bus.err_idx), 0);
        chk("t6_err_len",    32'(bus.err_len), 23);

        // frame_cnt wrap on the 4-bit instance
        hold2(1'b0, 5);
        for (int k = 0; k < 16; k++) begin
            hold2(1'b1, 3);
            hold2(1'b0, 3);
        end
        hold2(1'b1, 3);
        chk("wrap_frame_cnt0", 32'(bus2.frame_cnt), 0);
        chk("wrap_fok16",      n_fok2, 16);
        hold2(1'b0, 3);
        hold2(1'b1, 3);
        chk("wrap_frame_cnt1", 32'(bus2.frame_cnt), 1);
        chk("wrap_fok17",      n_fok2, 17);
        chk("wrap_no_err",     n_err2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
